// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming SHA-256 / SHA256d engine.
// Reads a word-aligned message from word-addressed memory, pads it on the fly,
// compresses it block by block through a rolling 16-word schedule, optionally
// hashes the digest a second time, and writes the 8-word digest back.
module sha256_stream_core #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dbl,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [LEN_W-1:0]  msg_words,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    // Global word index needs room for msg_words + padding (+18) without overflow.
    localparam int G_W = LEN_W + 2;
    localparam int B_W = G_W - 4;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_COMPUTE, S_FINAL, S_FETCH2, S_WRITE
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              dbl_q, dbl_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] msg_addr_q, msg_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [B_W-1:0]    nb_q, nb_d;
    logic [B_W-1:0]    blk_q, blk_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [31:0]       h_q [8];
    logic [31:0]       h_d [8];
    logic [31:0]       st_q [8];   // working variables a..h
    logic [31:0]       st_d [8];
    logic [31:0]       w_q [16];   // w_q[0] is the word consumed this round
    logic [31:0]       w_d [16];

    logic [B_W-1:0]    blk_next;
    logic [3:0]        fetch_k;
    logic [G_W-1:0]    fetch_g;
    logic [G_W-1:0]    last_g;
    logic [G_W-1:0]    len_g;
    logic [63:0]       len_bits;
    logic [31:0]       fetch_word;
    logic [31:0]       w_new;
    logic [31:0]       t1, t2;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] next_blk_addr;

    assign blk_next      = blk_q + 1'b1;
    assign fetch_k       = 4'(cnt_q - 7'd1);
    assign fetch_g       = {blk_q, 4'b0000} + G_W'(fetch_k);
    assign last_g        = {nb_q, 4'b0000} - G_W'(1);
    assign len_g         = G_W'(len_q);
    assign len_bits      = 64'(len_q) << 5;
    assign fetch_addr    = msg_addr_q + ADDR_W'({blk_q, 4'b0000}) + ADDR_W'(cnt_q) + ADDR_W'(1);
    assign next_blk_addr = msg_addr_q + ADDR_W'({blk_next, 4'b0000});

    // Word w[t+16], appended to the schedule window as w[t] is consumed.
    assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    // One compression round on the current working variables.
    assign t1 = st_q[7] + bsig1(st_q[4]) + ((st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6]))
              + K[cnt_q[5:0]] + w_q[0];
    assign t2 = bsig0(st_q[0]) + ((st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2]) ^ (st_q[1] & st_q[2]));

    // Message word or on-the-fly padding for the slot captured this FETCH cycle.
    always_comb begin
        fetch_word = 32'h0;
        if (fetch_g < len_g) begin
            fetch_word = mem_read_data;
        end else if (fetch_g == len_g) begin
            fetch_word = 32'h80000000;
        end else if (fetch_g == last_g) begin
            fetch_word = len_bits[31:0];
        end else if (fetch_g == last_g - G_W'(1)) begin
            fetch_word = len_bits[63:32];
        end
    end

    // Next-state and datapath update for the whole engine.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dbl_d       = dbl_q;
        pass_d      = pass_q;
        msg_addr_d  = msg_addr_q;
        out_addr_d  = out_addr_q;
        len_d       = len_q;
        nb_d        = nb_q;
        blk_d       = blk_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < 8; i++) begin
            h_d[i]  = h_q[i];
            st_d[i] = st_q[i];
        end
        for (int i = 0; i < 16; i++) begin
            w_d[i] = w_q[i];
        end

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !done_q) begin
                    dbl_d      = dbl;
                    msg_addr_d = message_addr;
                    out_addr_d = output_addr;
                    len_d      = msg_words;
                    nb_d       = B_W'((G_W'(msg_words) + G_W'(18)) >> 4);
                    blk_d      = '0;
                    cnt_d      = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    mem_addr_d = message_addr;
                    for (int i = 0; i < 8; i++) h_d[i] = IV[i];
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                // Memory returns data one cycle after the address, so capture lags by one.
                if (cnt_q != 7'd0) begin
                    for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                    w_d[15] = fetch_word;
                end
                if (cnt_q < 7'd15) begin
                    mem_addr_d = fetch_addr;
                end
                if (cnt_q == 7'd16) begin
                    for (int i = 0; i < 8; i++) st_d[i] = h_q[i];
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end

            S_COMPUTE: begin
                st_d[7] = st_q[6];
                st_d[6] = st_q[5];
                st_d[5] = st_q[4];
                st_d[4] = st_q[3] + t1;
                st_d[3] = st_q[2];
                st_d[2] = st_q[1];
                st_d[1] = st_q[0];
                st_d[0] = t1 + t2;
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = w_new;
                if (cnt_q == 7'd63) begin
                    cnt_d   = '0;
                    state_d = S_FINAL;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end

            S_FINAL: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + st_q[i];
                cnt_d = '0;
                if (blk_next < nb_q) begin
                    blk_d      = blk_next;
                    mem_addr_d = next_blk_addr;
                    state_d    = S_FETCH;
                end else if (dbl_q && !pass_q) begin
                    pass_d  = 1'b1;
                    state_d = S_FETCH2;
                end else begin
                    state_d = S_WRITE;
                end
            end

            S_FETCH2: begin
                // Second pass: the 256-bit digest is a single, fixed-padding block.
                if (cnt_q == 7'd16) begin
                    for (int i = 0; i < 8; i++) begin
                        w_d[i]  = h_q[i];
                        h_d[i]  = IV[i];
                        st_d[i] = IV[i];
                    end
                    w_d[8] = 32'h80000000;
                    for (int i = 9; i < 15; i++) w_d[i] = 32'h0;
                    w_d[15] = 32'h00000100;
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end

            S_WRITE: begin
                if (cnt_q < 7'd8) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = out_addr_q + ADDR_W'(cnt_q);
                    mem_wdata_d = h_q[cnt_q[2:0]];
                    cnt_d       = cnt_q + 7'd1;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any hash in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dbl_q       <= 1'b0;
            pass_q      <= 1'b0;
            msg_addr_q  <= '0;
            out_addr_q  <= '0;
            len_q       <= '0;
            nb_q        <= '0;
            blk_q       <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= '0;
                st_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dbl_q       <= dbl_d;
            pass_q      <= pass_d;
            msg_addr_q  <= msg_addr_d;
            out_addr_q  <= out_addr_d;
            len_q       <= len_d;
            nb_q        <= nb_d;
            blk_q       <= blk_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= h_d[i];
                st_q[i] <= st_d[i];
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: directed checks of sha256_stream_core against known
// digests and a plain full-buffer SHA-256 reference function.
module tb_sha256_stream_core;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_ABCD =
        256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589;
    localparam logic [255:0] DIG_EMPTY_D =
        256'h5df6e0e2_761359d3_0a827505_8e299fcc_03815345_45f55cf4_3e41983f_5d4c9456;
    localparam logic [255:0] POISON = {8{32'hdeadbeef}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        dbl = 1'b0;
    logic [15:0] message_addr = '0;
    logic [15:0] output_addr = '0;
    logic [15:0] msg_words = '0;
    logic        busy, done, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:65535];
    int tests = 0;
    int fails = 0;
    logic [31:0] q13 [$];
    logic [31:0] q14 [$];
    logic [31:0] q20 [$];

    sha256_stream_core #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .dbl(dbl),
        .message_addr(message_addr), .output_addr(output_addr), .msg_words(msg_words),
        .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_write_data;
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [31:0] m [16]);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] x1, x2;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return hout;
    endfunction

    function automatic logic [255:0] ref_hash(input logic [31:0] msg [$], input bit d);
        logic [31:0] p [$];
        logic [31:0] blk [16];
        logic [255:0] h;
        p = msg;
        h = IV256;
        for (int pass = 0; pass < (d ? 2 : 1); pass++) begin
            int n;
            n = p.size();
            p.push_back(32'h80000000);
            while (p.size() % 16 != 14) p.push_back(32'h0);
            p.push_back(32'h0);
            p.push_back(32'(n * 32));
            h = IV256;
            for (int b = 0; b < p.size() / 16; b++) begin
                for (int i = 0; i < 16; i++) blk[i] = p[16*b + i];
                h = compress(h, blk);
            end
            p = {};
            for (int i = 0; i < 8; i++) p.push_back(h[255-32*i -: 32]);
        end
        return h;
    endfunction

    function automatic logic [255:0] digest_at(input logic [15:0] o);
        logic [255:0] dg;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = o + 16'(i);
            dg[255-32*i -: 32] = mem[a];
        end
        return dg;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poison(input logic [15:0] o);
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = o + 16'(i);
            mem[a] = 32'hdeadbeef;
        end
    endtask

    // Waits from the negedge after the accepting edge (lat 0) until done, bounded.
    task automatic wait_done(input bit inject, output int lat, output int nwe,
                             output int fwe, output int bad, output logic b0);
        logic [15:0] oaddr;
        oaddr = output_addr;
        nwe = 0; fwe = -1; bad = 0; lat = 0; b0 = busy;
        while (lat < 400) begin
            if (done) break;
            if (mem_we) begin
                if (fwe < 0) fwe = lat;
                if (mem_addr !== oaddr + 16'(nwe)) bad++;
                nwe++;
            end
            if (inject && lat == 40) begin
                start = 1'b1; message_addr = 16'h0100; output_addr = 16'h2080;
                msg_words = 16'd5; dbl = 1'b1;
            end
            if (inject && lat == 41) start = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_run(input string name, input logic [15:0] oaddr, input logic [255:0] exp_dig,
                             input int exp_lat, input int lat, input int nwe, input int fwe,
                             input int bad, input logic b0);
        chk({name, "_digest"}, digest_at(oaddr), exp_dig);
        chk({name, "_latency"}, 256'(lat), 256'(exp_lat));
        chk({name, "_nwrites"}, 256'(nwe), 256'd8);
        chk({name, "_first_we"}, 256'(fwe), 256'(exp_lat - 8));
        chk({name, "_wr_addr"}, 256'(bad), 256'd0);
        chk({name, "_busy_start"}, 256'(b0), 256'd1);
        chk({name, "_busy_done"}, 256'(busy), 256'd0);
        $display("[TB] %s: latency %0d, writes %0d, digest %h", name, lat, nwe, digest_at(oaddr));
    endtask

    task automatic launch(input logic [15:0] maddr, input logic [15:0] oaddr,
                          input logic [15:0] n, input bit d);
        @(negedge clk);
        message_addr = maddr; output_addr = oaddr; msg_words = n; dbl = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_hash(input string name, input logic [15:0] maddr, input logic [15:0] oaddr,
                            input logic [15:0] n, input bit d, input bit inject,
                            input logic [255:0] exp_dig, input int exp_lat);
        int lat, nwe, fwe, bad;
        logic b0;
        poison(oaddr);
        launch(maddr, oaddr, n, d);
        wait_done(inject, lat, nwe, fwe, bad, b0);
        check_run(name, oaddr, exp_dig, exp_lat, lat, nwe, fwe, bad, b0);
    endtask

    initial begin
        int lat, nwe, fwe, bad, spur;
        logic b0;
        logic [15:0] a;

        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0300] = 32'h61626364;
        for (int i = 0; i < 13; i++) begin
            a = 16'h0400 + 16'(i); mem[a] = $urandom; q13.push_back(mem[a]);
        end
        for (int i = 0; i < 14; i++) begin
            a = 16'hfff8 + 16'(i); mem[a] = $urandom; q14.push_back(mem[a]);
        end
        for (int i = 0; i < 20; i++) begin
            a = 16'h0500 + 16'(i); mem[a] = $urandom; q20.push_back(mem[a]);
        end

        // Reset values
        #2;
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_we", 256'(mem_we), 256'd0);
        chk("rst_addr", 256'(mem_addr), 256'd0);
        chk("rst_wdata", 256'(mem_write_data), 256'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_hash("empty", 16'h0100, 16'h2000, 16'd0, 1'b0, 1'b0, DIG_EMPTY, 91);
        run_hash("abcd", 16'h0300, 16'h2010, 16'd1, 1'b0, 1'b0, DIG_ABCD, 91);
        run_hash("empty_dbl", 16'h0100, 16'h2020, 16'd0, 1'b1, 1'b0, DIG_EMPTY_D, 173);
        run_hash("w13", 16'h0400, 16'h2028, 16'd13, 1'b0, 1'b0, ref_hash(q13, 1'b0), 91);

        // Start held through the done pulse: ignored there, accepted one cycle later.
        poison(16'h2030);
        message_addr = 16'hfff8; output_addr = 16'h2030; msg_words = 16'd14; dbl = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("done_cycle_start_ignored", 256'(busy), 256'd0);
        @(negedge clk);
        chk("next_cycle_start_taken", 256'(busy), 256'd1);
        start = 1'b0;
        wait_done(1'b0, lat, nwe, fwe, bad, b0);
        check_run("w14_wrap", 16'h2030, ref_hash(q14, 1'b0), 173, lat, nwe, fwe, bad, b0);

        run_hash("w20", 16'h0500, 16'h2040, 16'd20, 1'b0, 1'b0, ref_hash(q20, 1'b0), 173);
        run_hash("w20_dbl", 16'h0500, 16'h2050, 16'd20, 1'b1, 1'b0, ref_hash(q20, 1'b1), 255);

        // Reset during COMPUTE round 30
        poison(16'h2060);
        launch(16'h0400, 16'h2060, 16'd13, 1'b0);
        repeat (47) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_done", 256'(done), 256'd0);
        chk("midrst_we", 256'(mem_we), 256'd0);
        chk("midrst_addr", 256'(mem_addr), 256'd0);
        chk("midrst_wdata", 256'(mem_write_data), 256'd0);
        @(negedge clk);
        reset = 1'b0;
        spur = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_we || done || busy) spur++;
        end
        chk("midrst_quiet", 256'(spur), 256'd0);
        chk("midrst_no_write", digest_at(16'h2060), POISON);
        $display("[TB] midrst: activity cycles after reset %0d", spur);
        run_hash("rst_recover", 16'h0400, 16'h2060, 16'd13, 1'b0, 1'b0, ref_hash(q13, 1'b0), 91);

        // Start pulsed while busy with other addresses
        poison(16'h2080);
        run_hash("busy_start", 16'h0300, 16'h2070, 16'd1, 1'b0, 1'b1, DIG_ABCD, 91);
        chk("busy_start_ghost", digest_at(16'h2080), POISON);
        repeat (3) @(negedge clk);
        chk("busy_start_idle", 256'(busy), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
